// File: rtl/aabb_stream_nearest.sv
// aabb_stream_nearest
//   Takes one ray, then a stream of axis-aligned boxes (one per cycle), and
//   reports the nearest box the ray enters: its arrival index and entry t.
//   Fixed-point Q(WIDTH-Q_BITS).Q_BITS throughout. The reciprocal direction
//   comes precomputed from upstream, so the slab test needs only multiplies.
//
//   Pipeline: S1 subtract origin, S2 scale by inv_dir with saturation,
//   S3 slab reduce and nearest-hit accumulate. The result appears 3 cycles
//   after the last box handshake.
//
// Ports
//   clk, reset_n                 clock, synchronous active-low reset
//   ray_valid/ray_ready          ray handshake (ready only when idle)
//   ray_origin, ray_inv_dir      {z,y,x} fixed-point vectors
//   ray_dir_zero                 per-axis "direction is zero" flags (bit0 = x)
//   ray_tlimit                   hits farther than this are rejected
//   box_valid/box_ready          box handshake (ready while streaming)
//   box_min, box_max, box_last   {z,y,x} box corners, end-of-stream marker
//   res_valid/res_ready          result handshake
//   res_hit, res_index, res_tmin nearest hit (index 0 / t = MAX on miss)
//   res_overflow                 more than MAX_BOXES boxes were streamed
//
// Optional build macro: AABB_STREAM_STATS_EN
//   Adds stat_boxes / stat_hits, free-running counters of box handshakes and
//   S3 hits since reset (wrap at 2^32, unaffected by ray boundaries).
module aabb_stream_nearest #(
  parameter int WIDTH     = 32,
  parameter int Q_BITS    = 16,
  parameter int MAX_BOXES = 16,
  localparam int IDX_W    = (MAX_BOXES > 1) ? $clog2(MAX_BOXES) : 1
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 ray_valid,
  output logic                 ray_ready,
  input  logic [3*WIDTH-1:0]   ray_origin,
  input  logic [3*WIDTH-1:0]   ray_inv_dir,
  input  logic [2:0]           ray_dir_zero,
  input  logic [WIDTH-1:0]     ray_tlimit,
  input  logic                 box_valid,
  output logic                 box_ready,
  input  logic [3*WIDTH-1:0]   box_min,
  input  logic [3*WIDTH-1:0]   box_max,
  input  logic                 box_last,
  output logic                 res_valid,
  input  logic                 res_ready,
  output logic                 res_hit,
  output logic [IDX_W-1:0]     res_index,
  output logic [WIDTH-1:0]     res_tmin,
  output logic                 res_overflow
`ifdef AABB_STREAM_STATS_EN
  ,
  output logic [31:0]          stat_boxes,
  output logic [31:0]          stat_hits
`endif
);

  localparam logic signed [WIDTH-1:0]   T_MAX  = {1'b0, {(WIDTH-1){1'b1}}};
  localparam logic signed [WIDTH-1:0]   T_MIN  = {1'b1, {(WIDTH-1){1'b0}}};
  localparam logic signed [WIDTH-1:0]   T_ZERO = {WIDTH{1'b0}};
  localparam logic signed [2*WIDTH-1:0] P_MAX  = {{(WIDTH+1){1'b0}}, {(WIDTH-1){1'b1}}};
  localparam logic signed [2*WIDTH-1:0] P_MIN  = {{(WIDTH+1){1'b1}}, {(WIDTH-1){1'b0}}};
  localparam logic [IDX_W-1:0]          CNT_TOP = IDX_W'(MAX_BOXES - 1);

  typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, DRAIN = 2'd2, DONE = 2'd3} state_t;

  // Full 2*WIDTH product; sign-extending both operands first keeps the low
  // 2*WIDTH bits of the unsigned product equal to the signed product.
  function automatic logic signed [2*WIDTH-1:0] fx_mul(input logic signed [WIDTH-1:0] d,
                                                       input logic signed [WIDTH-1:0] r);
    fx_mul = {{WIDTH{d[WIDTH-1]}}, d} * {{WIDTH{r[WIDTH-1]}}, r};
  endfunction

  // Drop the fraction of the product and clamp into the WIDTH-bit range.
  function automatic logic signed [WIDTH-1:0] fx_sat(input logic signed [2*WIDTH-1:0] p);
    logic signed [2*WIDTH-1:0] s;
    s = p >>> Q_BITS;
    if (s > P_MAX)      fx_sat = T_MAX;
    else if (s < P_MIN) fx_sat = T_MIN;
    else                fx_sat = s[WIDTH-1:0];
  endfunction

  state_t state_r, state_s;

  logic signed [WIDTH-1:0] org_r [3];
  logic signed [WIDTH-1:0] inv_r [3];
  logic [2:0]              dz_r;
  logic signed [WIDTH-1:0] tlim_r;

  logic signed [WIDTH-1:0] s1_d1_r [3];
  logic signed [WIDTH-1:0] s1_d2_r [3];
  logic [2:0]              s1_in_r;
  logic                    s1_valid_r, s1_last_r;
  logic [IDX_W-1:0]        s1_tag_r;

  logic signed [WIDTH-1:0] t1_s [3];
  logic signed [WIDTH-1:0] t2_s [3];
  logic                    miss_s;
  logic signed [WIDTH-1:0] s2_t1_r [3];
  logic signed [WIDTH-1:0] s2_t2_r [3];
  logic                    s2_valid_r, s2_last_r, s2_miss_r;
  logic [IDX_W-1:0]        s2_tag_r;

  logic signed [WIDTH-1:0] tnear_s, tfar_s, tmin_s, tmax_s, te_s;
  logic                    hit_s, s3_done_r;

  logic signed [WIDTH-1:0] best_r;
  logic                    hit_r, ovf_r, full_r;
  logic [IDX_W-1:0]        idx_r, cnt_r;

  logic ray_hs_s, box_hs_s;
  assign ray_hs_s = (state_r == IDLE) && ray_valid;
  assign box_hs_s = (state_r == RUN) && box_valid;

  // State register.
  always_ff @(posedge clk) begin
    if (!reset_n) state_r <= IDLE;
    else          state_r <= state_s;
  end

  // Next-state logic; DRAIN waits for the flag that the last box left S3.
  always_comb begin
    state_s = state_r;
    case (state_r)
      IDLE:    if (ray_valid) state_s = RUN; else state_s = IDLE;
      RUN:     if (box_valid && box_last) state_s = DRAIN; else state_s = RUN;
      DRAIN:   if (s3_done_r) state_s = DONE; else state_s = DRAIN;
      DONE:    if (res_ready) state_s = IDLE; else state_s = DONE;
      default: state_s = IDLE;
    endcase
  end

  // Handshake outputs decoded from the state register.
  always_comb begin
    ray_ready = 1'b0;
    box_ready = 1'b0;
    res_valid = 1'b0;
    case (state_r)
      IDLE:    ray_ready = 1'b1;
      RUN:     box_ready = 1'b1;
      DONE:    res_valid = 1'b1;
      default: ray_ready = 1'b0;
    endcase
  end

  // Ray capture.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      dz_r   <= 3'b000;
      tlim_r <= T_MAX;
      for (int a = 0; a < 3; a++) begin
        org_r[a] <= T_ZERO;
        inv_r[a] <= T_ZERO;
      end
    end else if (ray_hs_s) begin
      dz_r   <= ray_dir_zero;
      tlim_r <= ray_tlimit;
      for (int a = 0; a < 3; a++) begin
        org_r[a] <= ray_origin[a*WIDTH +: WIDTH];
        inv_r[a] <= ray_inv_dir[a*WIDTH +: WIDTH];
      end
    end
  end

  // S1: offsets from origin, plus the inside-slab test used by zero-direction axes.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      s1_valid_r <= 1'b0;
    end else begin
      s1_valid_r <= box_hs_s;
      if (box_hs_s) begin
        s1_last_r <= box_last;
        s1_tag_r  <= cnt_r;
        for (int a = 0; a < 3; a++) begin
          s1_d1_r[a] <= box_min[a*WIDTH +: WIDTH] - org_r[a];
          s1_d2_r[a] <= box_max[a*WIDTH +: WIDTH] - org_r[a];
          s1_in_r[a] <= ($signed(box_min[a*WIDTH +: WIDTH]) <= org_r[a]) &&
                        (org_r[a] <= $signed(box_max[a*WIDTH +: WIDTH]));
        end
      end
    end
  end

  // S2 combinational: slab distances; a zero-direction axis is all-or-nothing.
  always_comb begin
    miss_s = 1'b0;
    for (int a = 0; a < 3; a++) begin
      t1_s[a] = T_ZERO;
      t2_s[a] = T_ZERO;
      if (dz_r[a]) begin
        t1_s[a] = T_MIN;
        t2_s[a] = T_MAX;
        if (!s1_in_r[a]) miss_s = 1'b1;
        else             miss_s = miss_s;
      end else begin
        t1_s[a] = fx_sat(fx_mul(s1_d1_r[a], inv_r[a]));
        t2_s[a] = fx_sat(fx_mul(s1_d2_r[a], inv_r[a]));
      end
    end
  end

  // S2 register.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      s2_valid_r <= 1'b0;
    end else begin
      s2_valid_r <= s1_valid_r;
      if (s1_valid_r) begin
        s2_last_r <= s1_last_r;
        s2_tag_r  <= s1_tag_r;
        s2_miss_r <= miss_s;
        for (int a = 0; a < 3; a++) begin
          s2_t1_r[a] <= t1_s[a];
          s2_t2_r[a] <= t2_s[a];
        end
      end
    end
  end

  // S3 combinational: reduce the three slabs to an entry/exit interval.
  always_comb begin
    tnear_s = T_ZERO;
    tfar_s  = T_ZERO;
    tmin_s  = T_MIN;
    tmax_s  = T_MAX;
    for (int a = 0; a < 3; a++) begin
      if (s2_t1_r[a] < s2_t2_r[a]) begin
        tnear_s = s2_t1_r[a];
        tfar_s  = s2_t2_r[a];
      end else begin
        tnear_s = s2_t2_r[a];
        tfar_s  = s2_t1_r[a];
      end
      if (tnear_s > tmin_s) tmin_s = tnear_s; else tmin_s = tmin_s;
      if (tfar_s < tmax_s)  tmax_s = tfar_s;  else tmax_s = tmax_s;
    end
    if (tmin_s > T_ZERO) te_s = tmin_s; else te_s = T_ZERO;
    hit_s = s2_valid_r && !s2_miss_r && (tmax_s >= te_s) && (te_s <= tlim_r);
  end

  // S3 accumulate: strict less-than keeps the earliest box on ties.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      best_r    <= T_MAX;
      hit_r     <= 1'b0;
      idx_r     <= '0;
      s3_done_r <= 1'b0;
    end else begin
      s3_done_r <= s2_valid_r && s2_last_r;
      if (ray_hs_s) begin
        best_r <= T_MAX;
        hit_r  <= 1'b0;
        idx_r  <= '0;
      end else if (hit_s && (te_s < best_r)) begin
        best_r <= te_s;
        hit_r  <= 1'b1;
        idx_r  <= s2_tag_r;
      end
    end
  end

  // Box index counter; full marks that every index has been handed out once.
  always_ff @(posedge clk) begin
    if (!reset_n || ray_hs_s) begin
      cnt_r  <= '0;
      full_r <= 1'b0;
      ovf_r  <= 1'b0;
    end else if (box_hs_s) begin
      if (full_r)               ovf_r  <= 1'b1;
      else if (cnt_r == CNT_TOP) full_r <= 1'b1;
      else                      cnt_r  <= cnt_r + IDX_W'(1);
    end
  end

  assign res_hit      = hit_r;
  assign res_index    = idx_r;
  assign res_tmin     = best_r;
  assign res_overflow = ovf_r;

`ifdef AABB_STREAM_STATS_EN
  // Free-running activity counters.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      stat_boxes <= 32'd0;
      stat_hits  <= 32'd0;
    end else begin
      if (box_hs_s) stat_boxes <= stat_boxes + 32'd1;
      if (hit_s)    stat_hits  <= stat_hits + 32'd1;
    end
  end
`endif

endmodule
